// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Package : aes_pkg
// Brief   : Shared AES-128 decrypt types, constants and round/byte helpers.
// Revision: 1.0
// ============================================================================
package aes_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
`ifdef AES_DEC_KEYGEN_EN
        KEYGEN = 2'd1,
`endif
        ROUND  = 2'd2,
        DONE   = 2'd3
    } aes_fsm_t;

    // Byte 0 lives in bits [127:120]; byte idx = 4*column + row.
    function automatic logic [7:0] get_byte(input logic [127:0] s, input int idx);
        return s[127 - 8*idx -: 8];
    endfunction

    function automatic logic [127:0] put_byte(input logic [127:0] s, input int idx,
                                              input logic [7:0] b);
        logic [127:0] r;
        r = s;
        r[127 - 8*idx -: 8] = b;
        return r;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0 as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] acc;
        p   = x;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p   = gf_mul(p, p);
            acc = gf_mul(acc, p);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    function automatic logic [31:0] key_g(input logic [31:0] w, input logic [7:0] rc);
        return {sbox(w[23:16]) ^ rc, sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                r = put_byte(r, 4*c + row, get_byte(s, 4*((c - row + 4) % 4) + row));
        return r;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = get_byte(s, 4*c);
            a1 = get_byte(s, 4*c + 1);
            a2 = get_byte(s, 4*c + 2);
            a3 = get_byte(s, 4*c + 3);
            r = put_byte(r, 4*c,     gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09));
            r = put_byte(r, 4*c + 1, gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d));
            r = put_byte(r, 4*c + 2, gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b));
            r = put_byte(r, 4*c + 3, gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e));
        end
        return r;
    endfunction

    function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
        return s ^ k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_sbox.sv
`default_nettype none
// ============================================================================
// Module  : aes_inv_sbox
// Brief   : Byte-wide AES inverse S-box (inverse affine, then GF(2^8) inverse).
// Revision: 1.0
// ============================================================================
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    assign o_byte = gf_inv(inv_affine(i_byte));

endmodule
`default_nettype wire

// File: rtl/aes_decrypt.sv
`default_nettype none
// ============================================================================
// Module  : aes_decrypt
// Brief   : Iterative AES-128 inverse cipher, one round per clock.
//           AES_DEC_KEYGEN_EN: key input is k0, expanded forward to k10 first;
//           otherwise the key input is already k10.
// Revision: 1.0
// ============================================================================
module aes_decrypt
    import aes_pkg::*;
(
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext
);

    localparam logic [3:0] C_LAST_ROUND = 4'(NUM_ROUNDS - 1);

    aes_fsm_t     r_fsm;
    aes_fsm_t     w_fsm_next;
    logic [127:0] r_state;
    logic [127:0] r_key;
    logic [3:0]   r_round;

    logic [127:0] w_shifted;
    logic [127:0] w_subbed;
    logic [127:0] w_added;
    logic [127:0] w_mixed;
    logic [127:0] w_key_prev;
    logic [31:0]  w_g_in;
    logic [31:0]  w_g;
    logic [7:0]   w_rcon;

    // One g() is shared between the forward and inverse key schedules.
`ifdef AES_DEC_KEYGEN_EN
    logic [127:0] w_key_fwd;
    logic [31:0]  w_f0, w_f1, w_f2, w_f3;

    assign w_g_in = (r_fsm == KEYGEN) ? r_key[31:0] : (r_key[31:0] ^ r_key[63:32]);
    assign w_rcon = (r_fsm == KEYGEN) ? rcon(C_LAST_ROUND - r_round) : rcon(r_round);
    assign w_f0   = r_key[127:96] ^ w_g;
    assign w_f1   = r_key[95:64]  ^ w_f0;
    assign w_f2   = r_key[63:32]  ^ w_f1;
    assign w_f3   = r_key[31:0]   ^ w_f2;
    assign w_key_fwd = {w_f0, w_f1, w_f2, w_f3};
`else
    assign w_g_in = r_key[31:0] ^ r_key[63:32];
    assign w_rcon = rcon(r_round);
`endif

    assign w_g        = key_g(w_g_in, w_rcon);
    assign w_key_prev = {r_key[127:96] ^ w_g,
                         r_key[127:96] ^ r_key[95:64],
                         r_key[95:64]  ^ r_key[63:32],
                         r_key[63:32]  ^ r_key[31:0]};

    assign w_shifted = inv_shift_rows(r_state);

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_inv_sbox
            aes_inv_sbox u_inv_sbox (
                .i_byte (w_shifted[127 - 8*gi -: 8]),
                .o_byte (w_subbed[127 - 8*gi -: 8])
            );
        end
    endgenerate

    assign w_added = add_round_key(w_subbed, w_key_prev);
    assign w_mixed = inv_mix_columns(w_added);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_fsm <= IDLE;
        else        r_fsm <= w_fsm_next;
    end

    always_comb begin
        w_fsm_next = r_fsm;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (r_fsm)
            IDLE: begin
                in_ready = 1'b1;
`ifdef AES_DEC_KEYGEN_EN
                if (in_valid) w_fsm_next = KEYGEN;
`else
                if (in_valid) w_fsm_next = ROUND;
`endif
            end
`ifdef AES_DEC_KEYGEN_EN
            KEYGEN: if (r_round == 4'd0) w_fsm_next = ROUND;
`endif
            ROUND:  if (r_round == 4'd0) w_fsm_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_fsm_next = IDLE;
            end
            default: w_fsm_next = IDLE;
        endcase
    end

    assign plaintext = out_valid ? r_state : '0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= '0;
            r_key   <= '0;
            r_round <= 4'd0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid) begin
`ifdef AES_DEC_KEYGEN_EN
                        r_state <= ciphertext;
`else
                        r_state <= add_round_key(ciphertext, key);
`endif
                        r_key   <= key;
                        r_round <= C_LAST_ROUND;
                    end
                end
`ifdef AES_DEC_KEYGEN_EN
                KEYGEN: begin
                    r_key <= w_key_fwd;
                    // Last expansion step yields k10: whiten the ciphertext with it.
                    if (r_round == 4'd0) begin
                        r_state <= add_round_key(r_state, w_key_fwd);
                        r_round <= C_LAST_ROUND;
                    end else begin
                        r_round <= r_round - 4'd1;
                    end
                end
`endif
                ROUND: begin
                    r_state <= (r_round == 4'd0) ? w_added : w_mixed;
                    r_key   <= w_key_prev;
                    if (r_round != 4'd0) r_round <= r_round - 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_decrypt.sv
`default_nettype none
// ============================================================================
// Module  : tb_aes_decrypt
// Brief   : Self-checking bench for aes_decrypt against a behavioural AES-128
//           encryptor; honours AES_DEC_KEYGEN_EN for key format and latency.
// Revision: 1.0
// ============================================================================
module tb_aes_decrypt;

    // Cycle 1 is the clock period that begins at the transfer edge.
`ifdef AES_DEC_KEYGEN_EN
    localparam int LAT = 21;
`else
    localparam int LAT = 11;
`endif

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ciphertext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plaintext;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [7:0] sbox_t [256];

    always #5 CLK = ~CLK;

    aes_decrypt dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext)
    );

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [127:0] rk(input logic [127:0] k0, input int rnd);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sbox_t[t[23:16]] ^ rc, sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*rnd], w[4*rnd+1], w[4*rnd+2], w[4*rnd+3]};
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k0);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] k, res;
        k = rk(k0, 0);
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ k[127 - 8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[4*c + r] = t[4*((c + r) % 4) + r];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            k = rk(k0, rnd);
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127 - 8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] dut_key(input logic [127:0] k0);
`ifdef AES_DEC_KEYGEN_EN
        return k0;
`else
        return rk(k0, 10);
`endif
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One full transaction; 'hold' keeps in_valid high with junk data while busy.
    task automatic run_vec(input string tag, input logic [127:0] ct, input logic [127:0] k,
                           input logic [127:0] exp, input bit hold, input int bp);
        int n;
        check({tag, ":in_ready"}, 128'(in_ready), 128'd1);
        in_valid   = 1'b1;
        ciphertext = ct;
        key        = k;
        tick();
        if (!hold) in_valid = 1'b0;
        check({tag, ":busy"}, {126'd0, in_ready, out_valid}, 128'd0);
        check({tag, ":pt_zero"}, plaintext, 128'd0);
        n = 1;
        while (!out_valid && n < LAT + 20) begin
            if (hold) begin ciphertext = rand128(); key = rand128(); end
            tick();
            n++;
        end
        check({tag, ":latency"}, 128'(n), 128'(LAT));
        check({tag, ":plaintext"}, plaintext, exp);
        for (int i = 0; i < bp; i++) begin
            if (hold) begin ciphertext = rand128(); key = rand128(); end
            tick();
            check({tag, ":stall_pt"}, plaintext, exp);
            check({tag, ":stall_hs"}, {126'd0, in_ready, out_valid}, 128'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, ":released"}, {126'd0, in_ready, out_valid}, 128'd2);
        check({tag, ":pt_cleared"}, plaintext, 128'd0);
    endtask

    initial begin
        logic [7:0]   inv, b;
        logic [127:0] pt, k0, fips_key;
        int           stale;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                          ^ {b[3:0], b[7:4]} ^ 8'h63;
        end

        RST_N      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        ciphertext = '0;
        key        = '0;
        #1;
        check("reset:in_ready", 128'(in_ready), 128'd1);
        check("reset:out_valid", 128'(out_valid), 128'd0);
        check("reset:plaintext", plaintext, 128'd0);
        tick();
        tick();
        RST_N = 1'b1;
        tick();

`ifdef AES_DEC_KEYGEN_EN
        fips_key = 128'h000102030405060708090a0b0c0d0e0f;
`else
        fips_key = 128'h13111d7fe3944a17f307a78b4d2b30c5;
`endif
        run_vec("fips", 128'h69c4e0d86a7b0430d8cdb78070b4c55a, fips_key,
                128'h00112233445566778899aabbccddeeff, 1'b0, 0);

        pt = rand128(); k0 = rand128();
        run_vec("backpressure", aes_enc(pt, k0), dut_key(k0), pt, 1'b0, 5);

        // Abort mid-operation: outputs must clear without a clock edge.
        pt = rand128(); k0 = rand128();
        in_valid   = 1'b1;
        ciphertext = aes_enc(pt, k0);
        key        = dut_key(k0);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        RST_N = 1'b0;
        #1;
        check("midreset:in_ready", 128'(in_ready), 128'd1);
        check("midreset:out_valid", 128'(out_valid), 128'd0);
        check("midreset:plaintext", plaintext, 128'd0);
        tick();
        tick();
        RST_N = 1'b1;
        stale = 0;
        for (int i = 0; i < LAT + 10; i++) begin
            tick();
            if (out_valid || plaintext != 128'd0) stale++;
        end
        check("midreset:stale", 128'(stale), 128'd0);
        pt = rand128(); k0 = rand128();
        run_vec("post_reset", aes_enc(pt, k0), dut_key(k0), pt, 1'b0, 0);

        pt = rand128(); k0 = rand128();
        run_vec("hold_in_valid", aes_enc(pt, k0), dut_key(k0), pt, 1'b1, 3);

        for (int v = 0; v < 8; v++) begin
            pt = rand128(); k0 = rand128();
            run_vec($sformatf("b2b%0d", v), aes_enc(pt, k0), dut_key(k0), pt, 1'b0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_decrypt.md
AES_DECRYPT -- requirements
Module: aes_decrypt

Interface
REQ-001 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port in_valid  input  1  ciphertext and key are valid.
REQ-004 SHALL have port in_ready  output  1  block can accept a new ciphertext.
REQ-005 SHALL have port ciphertext  input  128  block to decrypt; bits [127:120] = byte 0 (FIPS-197 column-major).
REQ-006 SHALL have port key  input  128  key material, same byte order; meaning set by REQ-022/023.
REQ-007 SHALL have port out_valid  output  1  plaintext holds a valid result.
REQ-008 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-009 SHALL have port plaintext  output  128  decrypted block, same byte order.

Function
REQ-010 SHALL implement the AES-128 inverse cipher (FIPS-197 sec. 5.3), one round per clock, iterative datapath.
REQ-011 SHALL use FSM states IDLE, KEYGEN (only with REQ-022), ROUND, DONE.
REQ-012 SHALL drive in_ready=1 only in IDLE; a transfer occurs when in_valid and in_ready are both 1 on a rising edge.
REQ-013 On transfer, SHALL capture state = ciphertext XOR k10, set round counter to 9, and enter ROUND (or KEYGEN, per REQ-022).
REQ-014 In ROUND, each cycle with counter r>=1 SHALL apply, in order: InvShiftRows, InvSubBytes, AddRoundKey(k_r), InvMixColumns, then decrement r.
REQ-015 At r=0, SHALL apply InvShiftRows, InvSubBytes and AddRoundKey(k0), with no InvMixColumns, then enter DONE.
REQ-016 SHALL derive round keys on the fly with the inverse key schedule: w[i-4] = w[i] XOR g(w[i-1]) for the column-0 word and w[i-4] = w[i] XOR w[i-1] otherwise, using Rcon in descending order 0x36 down to 0x01.
REQ-017 Without REQ-022, out_valid SHALL rise exactly 11 cycles after the transfer edge.
REQ-018 In DONE, SHALL hold out_valid=1 and plaintext stable until out_ready=1; it SHALL then return to IDLE on that edge.
REQ-019 in_valid SHALL be ignored in every state except IDLE; new input is accepted no earlier than the cycle after the DONE handshake.
REQ-020 While out_valid=0, plaintext SHALL be 0.

Reset
REQ-021 RST_N=0 SHALL immediately force IDLE, counter 0, state and key registers 0, in_ready=1, out_valid=0 and plaintext=0; an operation in progress is discarded without any output.

Configuration
REQ-022 With AES_DEC_KEYGEN_EN defined, key SHALL be the cipher key (k0), and the block SHALL spend 10 KEYGEN cycles expanding it forward to k10 before ROUND; out_valid SHALL then rise 21 cycles after transfer.
REQ-023 Without AES_DEC_KEYGEN_EN, key SHALL be the last round key (k10); the KEYGEN state and forward-schedule logic SHALL be absent.

Structure
REQ-024 SHALL place the FSM state enum, NUM_ROUNDS=10, the Rcon table and the byte-order helper functions in shared package aes_pkg.
REQ-025 SHALL instantiate one sub-module, aes_inv_sbox (byte-wide inverse S-box), 16 times for the state and reuse the forward S-box for key-schedule g().
REQ-026 SHALL implement InvShiftRows, InvMixColumns and AddRoundKey as functions in aes_pkg.

Verification
REQ-027 FIPS-197 C.1, no macro: key=13111d7fe3944a17f307a78b4d2b30c5, ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext=00112233445566778899aabbccddeeff, out_valid high 11 cycles after transfer.
REQ-028 Same vector with AES_DEC_KEYGEN_EN, key=000102030405060708090a0b0c0d0e0f -> same plaintext, out_valid high at cycle 21.
REQ-029 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> plaintext stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-030 Pulse RST_N low at round 5 -> outputs 0 at once; after release, a new vector decrypts correctly and no stale result appears.
REQ-031 Hold in_valid=1 with changing data during ROUND/DONE -> inputs ignored; the result matches the first captured vector.
REQ-032 Back-to-back: 8 random vectors checked against an encrypt reference model (the team AES encryptor) -> all plaintexts match.
